// File: rtl/alu_arbiter.sv
// Round-robin arbiter that shares one external combinational ALU between two
// requesters, registering the winner's operands and returning the captured result.
module alu_arbiter #(
    parameter  int unsigned WIDTH = 16,
    localparam int unsigned OP_W  = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic [OP_W-1:0]  req0_op,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic [OP_W-1:0]  req1_op,
    output logic             rsp0_valid,
    input  logic             rsp0_ready,
    output logic             rsp1_valid,
    input  logic             rsp1_ready,
    output logic [WIDTH-1:0] rsp_result,
    output logic [WIDTH-1:0] rsp_flags,
    output logic [WIDTH-1:0] alu_reg1,
    output logic [WIDTH-1:0] alu_reg2,
    output logic [OP_W-1:0]  alu_inst,
    input  logic [WIDTH-1:0] alu_result,
    input  logic [WIDTH-1:0] alu_flags,
    output logic [WIDTH-1:0] flags_q,
    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_e;

    typedef struct packed {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic [OP_W-1:0]  op;
    } op_t;

    state_e           state_q, state_d;
    op_t              op_q, op_d;
    logic             gnt_q, gnt_d;
    logic             last_grant_q, last_grant_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [WIDTH-1:0] rflags_q, rflags_d;
    logic [WIDTH-1:0] last_flags_q, last_flags_d;

    logic gnt_sel;
    logic accept;
    logic rsp_take;

    // Grant: alternate on a tie, otherwise whoever is asking; re-evaluated every IDLE cycle.
    always_comb begin
        gnt_sel = 1'b0;
        if (req0_valid && req1_valid) begin
            gnt_sel = ~last_grant_q;
        end else begin
            gnt_sel = ~req0_valid;
        end
        accept     = (state_q == IDLE) && (req0_valid || req1_valid);
        req0_ready = accept && !gnt_sel;
        req1_ready = accept && gnt_sel;
        rsp_take   = gnt_q ? rsp1_ready : rsp0_ready;
    end

    always_comb begin
        state_d      = state_q;
        op_d         = op_q;
        gnt_d        = gnt_q;
        last_grant_d = last_grant_q;
        result_d     = result_q;
        rflags_d     = rflags_q;
        last_flags_d = last_flags_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    op_d         = gnt_sel ? op_t'{req1_a, req1_b, req1_op}
                                           : op_t'{req0_a, req0_b, req0_op};
                    gnt_d        = gnt_sel;
                    last_grant_d = gnt_sel;
                    state_d      = EXEC;
                end
            end
            EXEC: begin
                result_d     = alu_result;
                rflags_d     = alu_flags;
                last_flags_d = alu_flags;
                state_d      = RESP;
            end
            RESP: begin
                if (rsp_take) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            op_q         <= '0;
            gnt_q        <= 1'b0;
            last_grant_q <= 1'b1;
            result_q     <= '0;
            rflags_q     <= '0;
            last_flags_q <= '0;
        end else begin
            state_q      <= state_d;
            op_q         <= op_d;
            gnt_q        <= gnt_d;
            last_grant_q <= last_grant_d;
            result_q     <= result_d;
            rflags_q     <= rflags_d;
            last_flags_q <= last_flags_d;
        end
    end

    // ALU inputs are only live while the operation executes.
    always_comb begin
        alu_reg1 = '0;
        alu_reg2 = '0;
        alu_inst = '0;
        if (state_q == EXEC) begin
            alu_reg1 = op_q.a;
            alu_reg2 = op_q.b;
            alu_inst = op_q.op;
        end
    end

    assign rsp0_valid = (state_q == RESP) && !gnt_q;
    assign rsp1_valid = (state_q == RESP) && gnt_q;
    assign rsp_result = result_q;
    assign rsp_flags  = rflags_q;
    assign flags_q    = last_flags_q;
    assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_alu_arbiter.sv
// Scoreboard bench for alu_arbiter with a behavioural ALU stand-in and reference model.
module tb_alu_arbiter;

    logic        clk;
    logic        reset;
    logic        req0_valid, req1_valid;
    logic        req0_ready, req1_ready;
    logic [15:0] req0_a, req0_b, req1_a, req1_b;
    logic [3:0]  req0_op, req1_op;
    logic        rsp0_valid, rsp1_valid;
    logic        rsp0_ready, rsp1_ready;
    logic [15:0] rsp_result, rsp_flags;
    logic [15:0] alu_reg1, alu_reg2;
    logic [3:0]  alu_inst;
    logic [15:0] alu_result, alu_flags;
    logic [15:0] flags_q;
    logic        busy;

    alu_arbiter #(.WIDTH(16)) dut (
        .clk(clk), .reset(reset),
        .req0_valid(req0_valid), .req0_ready(req0_ready),
        .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
        .req1_valid(req1_valid), .req1_ready(req1_ready),
        .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
        .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready),
        .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
        .rsp_result(rsp_result), .rsp_flags(rsp_flags),
        .alu_reg1(alu_reg1), .alu_reg2(alu_reg2), .alu_inst(alu_inst),
        .alu_result(alu_result), .alu_flags(alu_flags),
        .flags_q(flags_q), .busy(busy)
    );

    // Reference ALU: returns {flags, result}; flags bit0 C, 1 L, 2 O, 3 E, 4 N.
    function automatic logic [31:0] alu_model(input logic [15:0] a, input logic [15:0] b,
                                              input logic [3:0] op);
        logic [16:0] s;
        logic [15:0] r;
        logic c, l, o, e, n;
        s = '0; r = '0; c = 1'b0; l = 1'b0; o = 1'b0; e = 1'b0; n = 1'b0;
        case (op[2:0])
            3'd0: begin
                if (op[3]) s = {1'b0, a} + {1'b0, ~b} + 17'd1;
                else       s = {1'b0, a} + {1'b0, b};
                r = s[15:0];
                c = s[16];
                l = (b < a);
                o = op[3] ? ((a[15] != b[15]) && (r[15] != a[15]))
                          : ((a[15] == b[15]) && (r[15] != a[15]));
                e = (a == b);
                n = r[15];
            end
            3'd1: begin r = a & b; e = (a == b); n = r[15]; end
            3'd2: begin r = a | b; e = (a == b); n = r[15]; end
            3'd3: begin r = a ^ b; e = (a == b); n = r[15]; end
            default: ;
        endcase
        return {11'd0, n, e, o, l, c, r};
    endfunction

    assign {alu_flags, alu_result} = alu_model(alu_reg1, alu_reg2, alu_inst);

    typedef struct {
        int          id;
        logic [15:0] a, b;
        logic [3:0]  op;
        logic [15:0] res, flg;
        int          acc;
        bit          seen;
    } sb_t;

    typedef struct {
        int          id;
        logic [15:0] res, flg;
    } log_t;

    sb_t         sb_q[$];
    log_t        rsp_log[$];
    int          gnt_id_log[$];
    int          gnt_cyc_log[$];
    int          hs_cyc_log[$];
    logic [15:0] exp_flags;
    int          cyc;
    int          n_chk, n_pass;
    bit          hold0, rnd_rdy;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    endtask

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Response-ready driver: always ready, randomly ready, or held off for requester 0.
    initial begin
        rsp0_ready = 1'b0;
        rsp1_ready = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            rsp0_ready = hold0 ? 1'b0 : (rnd_rdy ? 1'($urandom_range(0, 1)) : 1'b1);
            rsp1_ready = rnd_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Monitor: records accepts into the scoreboard and checks every presented response.
    always @(negedge clk) begin
        sb_t         f;
        logic [31:0] m;
        bit          ex;
        if (reset) begin
            chk("rsp_valid_excl", 32'(rsp0_valid & rsp1_valid), 32'd0);
            chk("ready_wo_valid", 32'((req0_ready & ~req0_valid) | (req1_ready & ~req1_valid)), 32'd0);
            chk("busy", 32'(busy), 32'(sb_q.size() != 0));
            ex = busy && !rsp0_valid && !rsp1_valid;
            if (ex && sb_q.size() != 0) begin
                chk("alu_operands", {alu_reg1, alu_reg2}, {sb_q[0].a, sb_q[0].b});
                chk("alu_inst", 32'(alu_inst), 32'(sb_q[0].op));
            end else if (!ex) begin
                chk("alu_idle_operands", {alu_reg1, alu_reg2}, 32'd0);
                chk("alu_idle_inst", 32'(alu_inst), 32'd0);
            end
            if (rsp0_valid || rsp1_valid) begin
                if (sb_q.size() == 0) begin
                    chk("spurious_rsp", 32'd1, 32'd0);
                end else begin
                    f = sb_q[0];
                    if (!f.seen) begin
                        chk("latency", 32'(cyc), 32'(f.acc + 2));
                        sb_q[0].seen = 1'b1;
                        exp_flags = f.flg;
                    end
                    chk("rsp_id", 32'(rsp1_valid), 32'(f.id));
                    chk("rsp_result", 32'(rsp_result), 32'(f.res));
                    chk("rsp_flags", 32'(rsp_flags), 32'(f.flg));
                    if ((rsp0_valid && rsp0_ready) || (rsp1_valid && rsp1_ready)) begin
                        rsp_log.push_back('{f.id, rsp_result, rsp_flags});
                        hs_cyc_log.push_back(cyc);
                        void'(sb_q.pop_front());
                    end
                end
            end
            chk("flags_q", 32'(flags_q), 32'(exp_flags));
            if ((req0_valid && req0_ready) || (req1_valid && req1_ready)) begin
                f.id = req1_ready ? 1 : 0;
                f.a  = req1_ready ? req1_a : req0_a;
                f.b  = req1_ready ? req1_b : req0_b;
                f.op = req1_ready ? req1_op : req0_op;
                m = alu_model(f.a, f.b, f.op);
                f.res  = m[15:0];
                f.flg  = m[31:16];
                f.acc  = cyc;
                f.seen = 1'b0;
                sb_q.push_back(f);
                gnt_id_log.push_back(f.id);
                gnt_cyc_log.push_back(cyc);
            end
        end
    end

    task automatic set_req(input int r, input logic v, input logic [15:0] a, input logic [15:0] b,
                           input logic [3:0] op);
        if (r == 0) begin
            req0_valid = v; req0_a = a; req0_b = b; req0_op = op;
        end else begin
            req1_valid = v; req1_a = a; req1_b = b; req1_op = op;
        end
    endtask

    // Present one request until accepted (or randomly withdrawn when wd is set).
    task automatic drive(input int r, input logic [15:0] a, input logic [15:0] b,
                         input logic [3:0] op, input bit wd);
        set_req(r, 1'b1, a, b, op);
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if ((r == 0) ? req0_ready : req1_ready) begin
                @(posedge clk);
                #2;
                set_req(r, 1'b0, a, b, op);
                return;
            end
            if (wd && $urandom_range(0, 7) == 0) begin
                @(posedge clk);
                #2;
                set_req(r, 1'b0, a, b, op);
                return;
            end
        end
        chk("req_accept_timeout", 32'd0, 32'd1);
        set_req(r, 1'b0, a, b, op);
    endtask

    task automatic sync();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_log(input int n);
        for (int i = 0; i < 300; i++) begin
            if (rsp_log.size() >= n) return;
            @(posedge clk);
        end
        chk("rsp_timeout", 32'(rsp_log.size()), 32'(n));
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 400; i++) begin
            if (sb_q.size() == 0 && !busy) return;
            @(posedge clk);
        end
        chk("idle_timeout", 32'(sb_q.size()), 32'd0);
    endtask

    task automatic chk_last(input string nm, input int id, input logic [15:0] res,
                            input logic [15:0] flg);
        log_t l;
        if (rsp_log.size() == 0) begin
            chk(nm, 32'd0, 32'd1);
            return;
        end
        l = rsp_log[rsp_log.size() - 1];
        chk(nm, {8'(l.id), 8'(l.flg), l.res}, {8'(id), 8'(flg), res});
    endtask

    initial begin
        int n0;
        int ng;
        bit got;
        logic [15:0] r_hold, f_hold;
        cyc = 0; n_chk = 0; n_pass = 0; exp_flags = '0;
        hold0 = 1'b0; rnd_rdy = 1'b0;
        reset = 1'b0;
        set_req(0, 1'b0, '0, '0, '0);
        set_req(1, 1'b0, '0, '0, '0);

        // Reset state
        #12;
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_handshake", 32'({req0_ready, req1_ready, rsp0_valid, rsp1_valid}), 32'd0);
        chk("reset_rsp", {rsp_result, rsp_flags}, 32'd0);
        chk("reset_flags_q", 32'(flags_q), 32'd0);
        repeat (2) @(posedge clk);
        #2 reset = 1'b1;
        sync();

        // Add from requester 0
        drive(0, 16'h0005, 16'h0003, 4'b0000, 1'b0);
        wait_log(1);
        chk_last("add", 0, 16'h0008, 16'h0002);
        chk("add_flags_q", 32'(flags_q), 32'h0002);

        // Subtract from requester 1
        sync();
        drive(1, 16'h0005, 16'h0005, 4'b1000, 1'b0);
        wait_log(2);
        chk_last("sub", 1, 16'h0000, 16'h0009);

        // Tie: requester 0 served first, then 1
        sync();
        fork
            drive(0, 16'hFFFF, 16'hFFFF, 4'b0011, 1'b0);
            drive(1, 16'h00F0, 16'h000F, 4'b0010, 1'b0);
        join
        wait_log(4);
        chk("tie_first", {8'(rsp_log[2].id), 8'(rsp_log[2].flg), rsp_log[2].res}, {8'd0, 8'h08, 16'h0000});
        chk("tie_second", {8'(rsp_log[3].id), 8'(rsp_log[3].flg), rsp_log[3].res}, {8'd1, 8'h00, 16'h00FF});

        // Continuous contention alternates grants
        wait_idle();
        sync();
        ng = gnt_id_log.size();
        fork
            for (int k = 0; k < 2; k++) drive(0, 16'($urandom), 16'($urandom), 4'($urandom_range(0, 15)), 1'b0);
            for (int k = 0; k < 2; k++) drive(1, 16'($urandom), 16'($urandom), 4'($urandom_range(0, 15)), 1'b0);
        join
        chk("alternation", 32'({gnt_id_log[ng][0], gnt_id_log[ng+1][0], gnt_id_log[ng+2][0], gnt_id_log[ng+3][0]}), 32'b0101);
        wait_idle();

        // Back-pressure on requester 0 while requester 1 waits
        hold0 = 1'b1;
        sync();
        n0 = rsp_log.size();
        fork
            drive(0, 16'h0100, 16'h0011, 4'b1000, 1'b0);
            drive(1, 16'h8000, 16'h8000, 4'b0000, 1'b0);
            begin
                got = 1'b0;
                for (int i = 0; i < 50 && !got; i++) begin
                    @(negedge clk);
                    got = rsp0_valid;
                end
                #1;
                r_hold = rsp_result;
                f_hold = rsp_flags;
                chk("bp_value", {f_hold, r_hold}, {16'h0003, 16'h00EF});
                repeat (5) begin
                    @(negedge clk);
                    #1;
                    chk("bp_stable", {15'd0, rsp0_valid, rsp_result}, {15'd0, 1'b1, r_hold});
                    chk("bp_flags", 32'(rsp_flags), 32'(f_hold));
                    chk("bp_req1_blocked", 32'({req1_ready, busy}), 32'b01);
                end
                hold0 = 1'b0;
            end
        join
        wait_log(n0 + 2);
        chk("bp_next_accept", 32'(gnt_cyc_log[gnt_cyc_log.size() - 1]),
            32'(hs_cyc_log[hs_cyc_log.size() - 2] + 1));
        chk_last("bp_req1", 1, 16'h0000, 16'h000D);

        // Reset during EXEC drops the operation
        sync();
        drive(0, 16'h1234, 16'h0001, 4'b0000, 1'b0);
        @(negedge clk);
        #1 reset = 1'b0;
        #1;
        chk("rst_mid_busy", 32'(busy), 32'd0);
        chk("rst_mid_rsp", {rsp_result, flags_q}, 32'd0);
        chk("rst_mid_rsp_flags", 32'(rsp_flags), 32'd0);
        sb_q.delete();
        exp_flags = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1 reset = 1'b1;
        n0 = rsp_log.size();
        repeat (5) @(posedge clk);
        chk("rst_no_rsp", 32'(rsp_log.size()), 32'(n0));
        #2;
        ng = gnt_id_log.size();
        fork
            drive(0, 16'h0002, 16'h0001, 4'b1000, 1'b0);
            drive(1, 16'h0003, 16'h0003, 4'b0001, 1'b0);
        join
        chk("rst_tie_order", 32'({gnt_id_log[ng][0], gnt_id_log[ng+1][0]}), 32'b01);
        wait_idle();

        // Illegal opcodes yield zero result and flags
        sync();
        n0 = rsp_log.size();
        drive(0, 16'($urandom), 16'($urandom), 4'b0101, 1'b0);
        wait_log(n0 + 1);
        chk_last("invalid_op", 0, 16'h0000, 16'h0000);

        // Randomised traffic with withdrawals and random response back-pressure
        rnd_rdy = 1'b1;
        sync();
        fork
            for (int k = 0; k < 30; k++) begin
                repeat ($urandom_range(0, 3)) @(posedge clk);
                #2;
                drive(0, 16'($urandom), 16'($urandom), 4'($urandom_range(0, 15)), 1'b1);
            end
            for (int k = 0; k < 30; k++) begin
                repeat ($urandom_range(0, 3)) @(posedge clk);
                #2;
                drive(1, 16'($urandom), 16'($urandom), 4'($urandom_range(0, 15)), 1'b1);
            end
        join
        wait_idle();
        rnd_rdy = 1'b0;
        repeat (3) @(posedge clk);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

- Shares one combinational ALU between two requesters; the ALU is instantiated alongside this block.
- Arbitrates round-robin, registers the winner's operands and drives them onto the ALU.
- Captures the ALU result and flags, and returns them on the winner's response channel with a valid/ready handshake.
- Sits between the CPU execute stage (requester 0) and the address/auxiliary unit (requester 1); also publishes the flags of the last completed operation.

## Interface
- WIDTH, 16, datapath width of operands, result and flags
- clk  input  1  system clock, all state on rising edge
- reset  input  1  asynchronous, active-low reset
- req0_valid / req1_valid  input  1  requester has an operation pending
- req0_ready / req1_ready  output  1  request accepted this cycle
- req0_a, req0_b / req1_a, req1_b  input  WIDTH  operands (ALU reg1, reg2)
- req0_op / req1_op  input  4  ALU instruction: [2:0] opcode, [3] subtract
- rsp0_valid / rsp1_valid  output  1  response available
- rsp0_ready / rsp1_ready  input  1  requester takes response
- rsp_result  output  WIDTH  captured ALU result, shared by both response channels
- rsp_flags  output  WIDTH  captured ALU flags, shared by both response channels
- alu_reg1, alu_reg2  output  WIDTH  operands to the ALU
- alu_inst  output  4  instruction to the ALU
- alu_result, alu_flags  input  WIDTH  combinational ALU outputs
- flags_q  output  WIDTH  flags of the last completed op (bit0 C, 1 L, 2 O, 3 E, 4 N)
- busy  output  1  state is not IDLE

## Operation
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - Grant selection:
    - Both valid: grant the requester not granted last time.
    - One valid: grant that requester.
  - reqN_ready is combinational: high only in IDLE, and only for the granted requester.
  - On valid&&ready: latch a, b, op and the grant index, update last_grant, go to EXEC.
- EXEC:
  - alu_reg1/alu_reg2/alu_inst come from the latched registers.
  - At the clock edge: capture alu_result into rsp_result and alu_flags into rsp_flags and flags_q, then go to RESP.
- RESP:
  - rspN_valid is high for the granted requester only.
  - rsp_result and rsp_flags are held stable.
  - On rspN_ready, go to IDLE.
- Outside EXEC: alu_reg1, alu_reg2 and alu_inst are driven to 0.
- The op field is passed through unmodified; opcodes 100-111 are legal and yield whatever the ALU returns (0).
- No arithmetic is performed in this block.

## Timing
- Reset values:
  - state IDLE; last_grant = 1, so requester 0 wins the first tie.
  - rsp_result, rsp_flags and flags_q = 0.
  - All ready/valid outputs = 0; busy = 0.
- Latency:
  - Request accepted at edge T0.
  - Result captured at T1; rspN_valid is high in the cycle after T1.
  - Response handshake at the earliest at T2; the next request can be accepted at T3.
  - Peak throughput is one operation per 3 cycles.
- Back-pressure:
  - RESP holds indefinitely while rspN_ready is low.
  - Both reqN_ready stay low until the response is taken.
- A requester deasserting valid before acceptance loses nothing; grant is re-evaluated each IDLE cycle.
- rspN_ready asserted outside RESP, or on the non-granted channel, is ignored.
- Reset asserted mid-operation: state returns to IDLE immediately and the in-flight operation is dropped with no response.
- flags_q changes only at the EXEC capture edge.

## Test plan
- Add: req0 a=0x0005 b=0x0003 op=4'b0000.
  - Response: rsp0_valid 2 cycles after accept, rsp_result=0x0008, rsp_flags=0x0002 (L set).
  - flags_q=0x0002.
- Subtract: req1 a=0x0005 b=0x0005 op=4'b1000.
  - Response: rsp1_valid, rsp_result=0x0000, rsp_flags=0x0009 (C, E); rsp0_valid stays 0.
- Tie after reset: both valid, req0 XOR 0xFFFF^0xFFFF, req1 OR 0x00F0|0x000F.
  - req0 is served first: rsp_result=0x0000, rsp_flags=0x0008.
  - req1 follows: rsp_result=0x00FF, rsp_flags=0x0000.
  - With both still valid, grants alternate 0,1,0,1.
- Back-pressure: hold rsp0_ready low for 5 cycles with req1_valid high.
  - rsp0_valid, rsp_result and rsp_flags remain stable; req1_ready stays 0; busy=1.
  - req1 is accepted the cycle after the rsp0 handshake.
- Reset mid-operation: assert reset in EXEC.
  - Immediately: busy=0, rsp_result=0, flags_q=0.
  - After release: no response is emitted; the next tie goes to req0.
- Invalid opcode: req0 op=4'b0101 with any operands -> rsp_result=0x0000, rsp_flags=0x0000.
